// File: rtl/y_mat_pkg.sv
// Shared types and constants for the Y-matrix row-address sequencer.
// Word layout: sixteen 16-bit slots, slot 0 in the top bits.
package y_mat_pkg;

    localparam int SLOT_W         = 16;
    localparam int FIELD_W        = 10;
    localparam int SLOTS_PER_WORD = 16;
    localparam int WORD_W         = 256;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_e;

    // Bit offset of slot s inside a word: slot 0 is the most significant.
    function automatic logic [7:0] slot_off(input logic [3:0] s);
        return 8'(SLOT_W) * (8'd15 - {4'd0, s});
    endfunction

endpackage

// File: rtl/y_mat_row_sequencer_if.sv
// Control, memory-read and row-address stream signals of the sequencer.
// master is the sequencer side, slave is its environment.
interface y_mat_row_sequencer_if #(
    parameter int NUM_ROWS_W = 16,
    parameter int MEM_ADDR_W = 12
);

    logic                          start;
    logic [NUM_ROWS_W-1:0]         num_rows;
    logic                          busy;
    logic                          done;
    logic                          mem_rd_en;
    logic [MEM_ADDR_W-1:0]         mem_rd_addr;
    logic                          mem_rd_valid;
    logic [y_mat_pkg::WORD_W-1:0]  mem_rd_data;
    logic                          row_addr_valid;
    logic                          row_addr_ready;
    logic [y_mat_pkg::FIELD_W:0]   row_addr;
    logic [NUM_ROWS_W-1:0]         row_idx;

    modport master (
        input  start,
        input  num_rows,
        output busy,
        output done,
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_valid,
        input  mem_rd_data,
        output row_addr_valid,
        input  row_addr_ready,
        output row_addr,
        output row_idx
    );

    modport slave (
        output start,
        output num_rows,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_valid,
        output mem_rd_data,
        input  row_addr_valid,
        output row_addr_ready,
        input  row_addr,
        input  row_idx
    );

endinterface

// File: rtl/y_mat_slot_extract.sv
// 16:1 slot mux: pulls the 10-bit row address out of one word slot.
// Upper slot bits are dropped; output is zero while disabled.
module y_mat_slot_extract
    import y_mat_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [3:0]        slot,
    input  logic              en,
    output logic [FIELD_W:0]  addr
);

    always_comb begin
        addr = '0;
        if (en) begin
            addr = {1'b0, word[slot_off(slot) +: FIELD_W]};
        end
    end

endmodule

// File: rtl/y_mat_row_sequencer.sv
// Walks rows 0..num_rows-1, fetching one 256-bit word per 16 rows
// and streaming each row's address over a valid/ready handshake.
module y_mat_row_sequencer
    import y_mat_pkg::*;
#(
    parameter int NUM_ROWS_W = 16,
    parameter int MEM_ADDR_W = 12
) (
    input logic                   clock,
    input logic                   reset,
    y_mat_row_sequencer_if.master bus
);

    state_e                state_q, state_d;
    logic [NUM_ROWS_W-1:0] row_q, row_d;
    logic [NUM_ROWS_W-1:0] num_q, num_d;
    logic [WORD_W-1:0]     buf_q, buf_d;
    logic [NUM_ROWS_W-1:0] row_nxt;
    logic                  emit;
    logic [FIELD_W:0]      slot_addr;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        num_d   = num_q;
        buf_d   = buf_q;
        row_nxt = row_q + NUM_ROWS_W'(1);
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_rows == '0) begin
                        state_d = S_DONE;
                    end else begin
                        num_d   = bus.num_rows;
                        row_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rd_valid) begin
                    buf_d   = bus.mem_rd_data;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.row_addr_ready) begin
                    if (row_nxt == num_q) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_nxt;
                        // Crossing into a new word needs a fresh fetch.
                        if (row_nxt[3:0] == 4'd0) begin
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            num_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            num_q   <= num_d;
            buf_q   <= buf_d;
        end
    end

    assign emit = (state_q == S_EMIT);

    y_mat_slot_extract u_extract (
        .word (buf_q),
        .slot (row_q[3:0]),
        .en   (emit),
        .addr (slot_addr)
    );

    assign bus.busy           = (state_q != S_IDLE);
    assign bus.done           = (state_q == S_DONE);
    assign bus.mem_rd_en      = (state_q == S_REQ);
    assign bus.mem_rd_addr    = (state_q == S_REQ)
                              ? MEM_ADDR_W'(row_q[NUM_ROWS_W-1:4])
                              : '0;
    assign bus.row_addr_valid = emit;
    assign bus.row_addr       = slot_addr;
    assign bus.row_idx        = emit ? row_q : '0;

endmodule

// File: tb/tb_y_mat_row_sequencer.sv
// Directed bench for y_mat_row_sequencer with a row-stream scoreboard
// built from the memory image and a latency-configurable memory model.
module tb_y_mat_row_sequencer;
    import y_mat_pkg::*;

    localparam int NRW = 16;
    localparam int MAW = 12;

    typedef struct {
        int idx;
        int addr;
    } row_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    y_mat_row_sequencer_if #(.NUM_ROWS_W(NRW), .MEM_ADDR_W(MAW)) bus();

    y_mat_row_sequencer #(.NUM_ROWS_W(NRW), .MEM_ADDR_W(MAW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [255:0] mem [4];
    int           tests = 0;
    int           fails = 0;
    bit           chk_en = 1'b0;
    bit           resp_en = 1'b0;
    int           lat = 2;
    int           stall_left = 0;
    int           stall_row = -1;
    row_t         exp_q[$];
    int           exp_rd[$];
    int           n_xfer, n_rd, n_done;
    int           cyc = 0;
    logic [10:0]  cap [64];
    int           cap_cyc [64];

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input longint act);
        tests++;
        fails++;
        $display("FAIL %s: got 0x%0h expected none", nm, act);
    endtask

    // Row address straight from the memory image: slot r%16 of word r/16.
    function automatic int model_addr(input int r);
        logic [255:0] w;
        w = mem[(r / 16) % 4];
        w = w >> (240 - 16 * (r % 16));
        return int'(w[9:0]);
    endfunction

    always @(negedge clock) begin
        cyc++;
        if (chk_en) begin
            if (bus.row_addr_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("extra_row", longint'(bus.row_idx));
                end else begin
                    chk("row_idx", longint'(bus.row_idx), longint'(exp_q[0].idx));
                    chk("row_addr", longint'(bus.row_addr), longint'(exp_q[0].addr));
                    if (bus.row_addr_ready) begin
                        cap[exp_q[0].idx % 64] = bus.row_addr;
                        cap_cyc[exp_q[0].idx % 64] = cyc;
                        void'(exp_q.pop_front());
                        n_xfer++;
                    end
                end
            end
            if (bus.mem_rd_en) begin
                n_rd++;
                if (exp_rd.size() == 0) begin
                    fail_now("extra_read", longint'(bus.mem_rd_addr));
                end else begin
                    chk("rd_addr", longint'(bus.mem_rd_addr), longint'(exp_rd.pop_front()));
                end
            end
            if (bus.done) n_done++;
        end
    end

    initial begin
        int a;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        forever begin
            @(posedge clock);
            if (resp_en && bus.mem_rd_en) begin
                a = int'(bus.mem_rd_addr);
                repeat (lat - 1) @(posedge clock);
                #1;
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = mem[a % 4];
                @(posedge clock);
                #1;
                bus.mem_rd_valid = 1'b0;
                bus.mem_rd_data  = '0;
            end
        end
    end

    initial begin
        bus.row_addr_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (stall_left > 0 && bus.row_addr_valid &&
                int'(bus.row_idx) == stall_row) begin
                bus.row_addr_ready = 1'b0;
                stall_left--;
            end else begin
                bus.row_addr_ready = 1'b1;
            end
        end
    end

    task automatic pulse_start(input int n);
        @(posedge clock);
        #1;
        bus.start    = 1'b1;
        bus.num_rows = NRW'(n);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_seq(input int n, input int l, input int srow,
                           input int sn, input bit poke);
        int k;
        lat        = l;
        stall_row  = srow;
        stall_left = sn;
        exp_q.delete();
        exp_rd.delete();
        n_xfer = 0;
        n_rd   = 0;
        n_done = 0;
        for (int r = 0; r < n; r++) begin
            exp_q.push_back('{idx: r, addr: model_addr(r)});
            if (r % 16 == 0) exp_rd.push_back(r / 16);
        end
        chk_en  = 1'b1;
        resp_en = 1'b1;
        pulse_start(n);
        if (poke) begin
            repeat (2) @(posedge clock);
            #1;
            bus.start    = 1'b1;
            bus.num_rows = NRW'(n + 7);
            @(posedge clock);
            #1;
            bus.start = 1'b0;
        end
        k = 0;
        while (n_done == 0 && k < 400) begin
            @(posedge clock);
            k++;
        end
        if (n_done == 0) fail_now("done_timeout", longint'(k));
        @(negedge clock);
        @(negedge clock);
        chk("xfers", longint'(n_xfer), longint'(n));
        chk("reads", longint'(n_rd), longint'((n + 15) / 16));
        chk("done_pulses", longint'(n_done), 1);
        chk("rows_left", longint'(exp_q.size()), 0);
        chk("busy_after", longint'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.start    = 1'b0;
        bus.num_rows = '0;
        for (int w = 0; w < 4; w++) begin
            for (int s = 0; s < 16; s++) begin
                mem[w][16*(15-s) +: 16] = 16'hFC00 | 16'(((w * 16 + s) * 37) & 10'h3FF);
            end
        end
        mem[0][255:240] = 16'h0155;
        mem[0][239:224] = 16'h02AA;
        mem[0][223:208] = 16'h0001;
        mem[0][15:0]    = 16'hA123;
        mem[1][255:240] = 16'h7C3E;
        mem[1][239:224] = 16'h0200;

        // Model pinned against hand-decoded slot values.
        chk("model_r0", longint'(model_addr(0)), 'h155);
        chk("model_r15", longint'(model_addr(15)), 'h123);
        chk("model_r16", longint'(model_addr(16)), 'h03E);

        repeat (3) @(negedge clock);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_done", longint'(bus.done), 0);
        chk("rst_rd_en", longint'(bus.mem_rd_en), 0);
        chk("rst_valid", longint'(bus.row_addr_valid), 0);
        chk("rst_row_addr", longint'(bus.row_addr), 0);
        @(posedge clock);
        #1 reset = 1'b1;

        run_seq(3, 2, -1, 0, 1'b0);
        chk("t1_r0", longint'(cap[0]), 'h155);
        chk("t1_r1", longint'(cap[1]), 'h2AA);
        chk("t1_r2", longint'(cap[2]), 'h001);
        chk("t1_back_to_back", longint'(cap_cyc[2] - cap_cyc[0]), 2);

        run_seq(18, 3, -1, 0, 1'b0);
        chk("t2_r15", longint'(cap[15]), 'h123);
        chk("t2_r16", longint'(cap[16]), 'h03E);
        chk("t2_r17", longint'(cap[17]), 'h200);

        run_seq(4, 2, 1, 5, 1'b0);
        chk("t3_stalled", longint'(stall_left), 0);
        chk("t3_gap", longint'(cap_cyc[1] - cap_cyc[0]), 6);
        chk("t3_r1", longint'(cap[1]), 'h2AA);

        exp_q.delete();
        exp_rd.delete();
        n_xfer = 0;
        n_rd   = 0;
        n_done = 0;
        chk_en = 1'b1;
        pulse_start(0);
        @(negedge clock);
        chk("zero_done", longint'(bus.done), 1);
        @(negedge clock);
        chk("zero_done_off", longint'(bus.done), 0);
        chk("zero_busy_off", longint'(bus.busy), 0);
        repeat (4) @(negedge clock);
        chk("zero_reads", longint'(n_rd), 0);
        chk("zero_xfers", longint'(n_xfer), 0);
        chk("zero_done_cnt", longint'(n_done), 1);

        chk_en  = 1'b0;
        resp_en = 1'b0;
        pulse_start(1);
        k = 0;
        while (!bus.mem_rd_en && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (!bus.mem_rd_en) fail_now("wait_req_timeout", longint'(k));
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rw_busy", longint'(bus.busy), 0);
        chk("rw_done", longint'(bus.done), 0);
        chk("rw_rd_en", longint'(bus.mem_rd_en), 0);
        chk("rw_rd_addr", longint'(bus.mem_rd_addr), 0);
        chk("rw_valid", longint'(bus.row_addr_valid), 0);
        chk("rw_row_addr", longint'(bus.row_addr), 0);
        chk("rw_row_idx", longint'(bus.row_idx), 0);
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = mem[0];
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("rw_late_valid", longint'(bus.row_addr_valid), 0);
            chk("rw_late_busy", longint'(bus.busy), 0);
        end
        run_seq(1, 3, -1, 0, 1'b0);
        chk("rw_r0", longint'(cap[0]), 'h155);

        mem[0][255:240] = 16'hFFFF;
        run_seq(2, 1, -1, 0, 1'b1);
        chk("ffff_r0", longint'(cap[0]), 'h3FF);
        chk("ffff_r1", longint'(cap[1]), 'h2AA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/y_mat_row_sequencer.md
# y_mat_row_sequencer

Sequences Y-matrix row-address lookups over a range of rows for the change-in-Y integration datapath. It issues 256-bit word reads to Y-matrix storage and holds the returned word in a local buffer. It extracts one 10-bit row address per row from that word's 16-bit slots and streams the addresses to downstream logic over a valid/ready handshake. Each memory word is read only once per 16 consecutive rows.

## Interface
Parameters:
- NUM_ROWS_W, default 16, width of the row count and row index.
- MEM_ADDR_W, default 12, width of the memory word address. Must satisfy NUM_ROWS_W − 4 ≤ MEM_ADDR_W.

Ports:
- clock, input, 1, the single clock; all state is updated on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, requests a sequence; sampled only in IDLE.
- num_rows, input, NUM_ROWS_W, row count; sampled with start.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse when the sequence completes.
- mem_rd_en, output, 1, one-cycle read request.
- mem_rd_addr, output, MEM_ADDR_W, word address, equal to row[NUM_ROWS_W-1:4].
- mem_rd_valid, input, 1, read data valid.
- mem_rd_data, input, 256, read word.
- row_addr_valid, output, 1, row_addr and row_idx are valid.
- row_addr_ready, input, 1, downstream accepts.
- row_addr, output, 11, extracted address; bit 10 is always 0.
- row_idx, output, NUM_ROWS_W, row index of the current row_addr.

## Operation
- States: IDLE, REQ, WAIT, EMIT, DONE.
- IDLE → start=1:
  - If num_rows=0, go to DONE.
  - Otherwise latch num_rows, set row=0, go to REQ.
- start outside IDLE is ignored.
- REQ: drive mem_rd_en=1 and mem_rd_addr=row[NUM_ROWS_W-1:4] for exactly one cycle, then go to WAIT.
- WAIT: on mem_rd_valid=1, latch mem_rd_data into the word buffer and go to EMIT. mem_rd_valid is ignored in every other state.
- EMIT: row_addr_valid=1. Slot s=row[3:0].
  - Extraction: row_addr = {1'b0, buf[16*(15−s)+9 : 16*(15−s)]}. Slot 0 is bits [249:240]; slot 15 is bits [9:0].
  - Bits [15:10] of each slot are ignored.
- Handshake in EMIT: transfer occurs when valid and ready are both 1. On transfer:
  - If row+1 = num_rows, go to DONE.
  - Else if (row+1)[3:0]=0, increment row and go to REQ.
  - Else increment row and stay in EMIT.
- While ready=0, row_addr and row_idx hold stable.
- DONE: done=1 for one cycle, then go to IDLE.
- Reset, in any state and including mid-sequence: state=IDLE, row=0, buffer=0, and every output = 0. An in-flight read response after reset is dropped.

## Timing
- Start at edge N → REQ at N+1, with mem_rd_en high during that cycle.
- mem_rd_valid may arrive at any cycle ≥1 after the request. The latency is unbounded; there is no timeout.
- Latched data → row_addr_valid high the next cycle.
- Within one word, one address per cycle is sustained while ready=1.
- Word crossing costs 1 REQ cycle plus the memory latency plus 1 cycle.
- done asserts the cycle after the last transfer.
- All outputs are registered or decoded from registered state and the buffer. There is no combinational path from any input to any output.

## Structure
- Package y_mat_pkg holds:
  - the state enum;
  - SLOT_W=16, FIELD_W=10, SLOTS_PER_WORD=16, WORD_W=256;
  - the slot-offset function 16*(15−s).
- One sub-module, y_mat_slot_extract: a combinational 16:1 mux (word, slot → 11-bit address) returning 0 when its enable is low.
- The sequencer owns the FSM, counters, buffer and handshakes.

## Test plan
- num_rows=3; word 0 slots 0–2 = 0x0155, 0x02AA, 0x0001; latency 2; ready=1.
  - Required: one read at address 0.
  - Required: outputs 0x155, 0x2AA, 0x001 with row_idx 0, 1, 2 on consecutive cycles.
  - Required: done pulses once, then busy=0.
- num_rows=18.
  - Required: exactly two reads, at addresses 0 and 1.
  - Required: row 15 = word0 bits [9:0], row 16 = word1 bits [249:240].
  - Required: 18 transfers, then done.
- Backpressure: ready=0 for 5 cycles while row 1 is presented.
  - Required: row_addr and row_idx stay stable, with no extra read.
  - Required: the sequence resumes on ready=1 with no loss or duplication.
- num_rows=0.
  - Required: done pulses 1 cycle after start.
  - Required: mem_rd_en never asserts and row_addr_valid never asserts.
- Reset low during WAIT, with mem_rd_valid arriving afterward.
  - Required: all outputs 0 and state IDLE; the late data is not emitted.
  - Required: a new start with num_rows=1 completes normally.
- Slot value 0xFFFF → row_addr=0x3FF.
  - Required: start pulsed while busy has no effect on num_rows or the row count.
